// File: rtl/ringbuf_fir_sched.sv
// Ring-buffer FIR sequencer: NTAPS MACs per write pulse, done_o NTAPS+2 cycles after edge detect.
// No backpressure; pulses while busy are dropped and flag overrun_o. FIRSCHED_SAT_EN saturates result_o.
module ringbuf_fir_sched #(
    parameter int NTAPS      = 8,
    parameter int COEFF_W    = 18,
    parameter int COEFF_FRAC = 17,
    parameter int ACC_W      = 46
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wpulse_i,
    input  logic signed [23:0]        data_i,
    output logic        [3:0]         offset_o,
    output logic                      pop_o,
    output logic        [3:0]         coeff_addr_o,
    input  logic signed [COEFF_W-1:0] coeff_i,
    output logic        [23:0]        result_o,
    output logic                      done_o,
    output logic                      busy_o,
    output logic                      overrun_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int         PROD_W   = 24 + COEFF_W;
    localparam logic [3:0] LAST_TAP = 4'(NTAPS - 1);

    logic                    sync1_q, sync2_q, prev_q;
    logic [1:0]              state_q, state_d;
    logic [3:0]              tap_q, tap_d;
    logic                    vld_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [23:0]             result_q, result_d;
    logic                    overrun_q, overrun_d;
    logic                    pulse_edge;
    logic signed [PROD_W-1:0] prod;
    logic [23:0]             res_next;

    assign pulse_edge = sync2_q & ~prev_q;
    assign prod       = data_i * coeff_i;

    // Product lands one cycle after its tap was issued, tracked by vld_q.
    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_IDLE && pulse_edge) begin
            acc_d = '0;
        end else if (vld_q) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

`ifdef FIRSCHED_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = $signed({{(ACC_W-24){1'b0}}, 24'h7FFFFF});
    localparam logic signed [ACC_W-1:0] SAT_MIN = $signed({{(ACC_W-24){1'b1}}, 24'h800000});
    logic signed [ACC_W-1:0] shifted;
    assign shifted = acc_d >>> COEFF_FRAC;
    always_comb begin
        res_next = shifted[23:0];
        if (shifted > SAT_MAX) begin
            res_next = 24'h7FFFFF;
        end else if (shifted < SAT_MIN) begin
            res_next = 24'h800000;
        end
    end
`else
    assign res_next = acc_d[COEFF_FRAC +: 24];
`endif

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        result_d  = result_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (pulse_edge) begin
                    tap_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tap_q == LAST_TAP) begin
                    state_d = ST_DRAIN;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                // Result is registered as DONE is entered so it is valid alongside done_o.
                result_d = res_next;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pulse_edge && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            vld_q     <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= wpulse_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            tap_q     <= tap_d;
            vld_q     <= (state_q == ST_RUN);
            acc_q     <= acc_d;
            result_q  <= result_d;
            overrun_q <= overrun_d;
        end
    end

    assign offset_o     = (state_q == ST_RUN) ? tap_q : 4'd0;
    assign coeff_addr_o = offset_o;
    assign done_o       = (state_q == ST_DONE);
    assign pop_o        = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE);
    assign result_o     = result_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_ringbuf_fir_sched.sv
// Bench for ringbuf_fir_sched: directed scenarios plus random runs against a dot-product reference model.
module tb_ringbuf_fir_sched;
    localparam int NTAPS = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               wpulse_i = 1'b0;
    logic signed [23:0] data_i = '0;
    logic signed [17:0] coeff_i = '0;
    logic [3:0]         offset_o, coeff_addr_o;
    logic               pop_o, done_o, busy_o, overrun_o;
    logic [23:0]        result_o;

    ringbuf_fir_sched dut (
        .clk(clk), .rst(rst), .wpulse_i(wpulse_i), .data_i(data_i),
        .offset_o(offset_o), .pop_o(pop_o), .coeff_addr_o(coeff_addr_o),
        .coeff_i(coeff_i), .result_o(result_o), .done_o(done_o),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    logic [23:0] entry [16];
    logic [17:0] coef  [16];

    // Ring buffer and coefficient ROM: both answer one cycle after the address.
    always @(posedge clk) begin
        data_i  <= entry[offset_o];
        coeff_i <= coef[coeff_addr_o];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          done_cnt = 0;
    int          pop_cnt  = 0;
    int          done_at  = -1;
    logic [23:0] res_at_done = '0;
    int          offs[$];

    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            done_at     = cyc;
            res_at_done = result_o;
        end
        if (pop_o) pop_cnt++;
        if (busy_o) offs.push_back(int'(offset_o));
    end

    int checks   = 0;
    int failures = 0;
    int t0       = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Filter output from the taps: signed dot product, floor-scaled by 2^17, then wrapped or clamped.
    function automatic logic [23:0] model();
        longint acc = 0;
        longint sh;
        longint e, c;
        for (int k = 0; k < NTAPS; k++) begin
            e = $signed(entry[k]);
            c = $signed(coef[k]);
            acc += e * c;
        end
        sh = acc >>> 17;
`ifdef FIRSCHED_SAT_EN
        if (sh > 64'sh7FFFFF) sh = 64'sh7FFFFF;
        else if (sh < -64'sh800000) sh = -64'sh800000;
`endif
        return sh[23:0];
    endfunction

    task automatic set_all(input logic [23:0] e, input logic [17:0] c);
        for (int k = 0; k < 16; k++) begin
            entry[k] = e;
            coef[k]  = c;
        end
    endtask

    task automatic pulse(input int hold);
        @(posedge clk);
        #1;
        wpulse_i = 1'b1;
        t0 = cyc;
        repeat (hold) @(posedge clk);
        #1;
        wpulse_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic run_check(input string tag, input int hold, input bit use_const,
                             input logic [23:0] exp_const);
        int          base  = done_cnt;
        int          pbase = pop_cnt;
        logic [23:0] exp   = model();
        pulse(hold);
        wait_done(base + 1, tag);
        chk({tag, "_result"}, 64'(res_at_done), 64'(exp));
        if (use_const) chk({tag, "_const"}, 64'(res_at_done), 64'(exp_const));
        chk({tag, "_latency"}, 64'(done_at - t0), 64'(NTAPS + 4));
        repeat (4) @(negedge clk);
        chk({tag, "_one_done"}, 64'(done_cnt - base), 64'd1);
        chk({tag, "_one_pop"}, 64'(pop_cnt - pbase), 64'd1);
        chk({tag, "_held"}, 64'(result_o), 64'(exp));
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int obase, nrun, base, pbase, n;
        set_all(24'h0, 18'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            64'({offset_o, pop_o, coeff_addr_o, result_o, done_o, busy_o, overrun_o}), 64'd0);

        // Impulse: 0x10000 is 0.5 (0x20000 would be -1.0 in an 18-bit signed word)
        set_all(24'h0, 18'h0);
        coef[0]  = 18'h10000;
        entry[0] = 24'h123456;
        run_check("impulse", 3, 1'b1, 24'h091A2B);

        // Sum of taps with offset sweep
        set_all(24'h0, 18'h10000);
        for (int k = 0; k < NTAPS; k++) entry[k] = 24'(2 * (k + 1));
        obase = offs.size();
        run_check("sum", 4, 1'b1, 24'd36);
        nrun = offs.size() - obase;
        chk("sum_busy_cycles", 64'(nrun), 64'(NTAPS + 2));
        for (int k = 0; k < NTAPS + 2 && k < nrun; k++)
            chk($sformatf("sum_offset%0d", k), 64'(offs[obase + k]), 64'(k < NTAPS ? k : 0));

        // Saturation region, both signs
        set_all(24'h7FFFFF, 18'h1FFFF);
        run_check("sat_pos", 2, 1'b0, 24'h0);
        set_all(24'h800000, 18'h1FFFF);
        run_check("sat_neg", 2, 1'b0, 24'h0);
        set_all(24'h800000, 18'h20000);
        run_check("sat_negcoef", 2, 1'b0, 24'h0);

        // Overrun: second rise 5 clk after the first
        set_all(24'h0, 18'h10000);
        for (int k = 0; k < NTAPS; k++) entry[k] = 24'(2 * (k + 1));
        base = done_cnt;
        pulse(3);
        repeat (2) @(posedge clk);
        #1 wpulse_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 wpulse_i = 1'b0;
        wait_done(base + 1, "ovr");
        repeat (20) @(negedge clk);
        chk("ovr_single_done", 64'(done_cnt - base), 64'd1);
        chk("ovr_flag", 64'(overrun_o), 64'd1);
        run_check("ovr_after", 3, 1'b1, 24'd36);
        chk("ovr_sticky", 64'(overrun_o), 64'd1);

        // Reset mid-run at tap 3
        base  = done_cnt;
        pbase = pop_cnt;
        pulse(3);
        n = 0;
        while (offset_o !== 4'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_tap3", 64'(offset_o), 64'd3);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs",
            64'({offset_o, pop_o, coeff_addr_o, result_o, done_o, busy_o, overrun_o}), 64'd0);
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - base), 64'd0);
        chk("midrst_no_pop", 64'(pop_cnt - pbase), 64'd0);
        run_check("midrst_after", 3, 1'b1, 24'd36);

        // Back-to-back pulses 16 clk apart
        set_all(24'h0, 18'h0);
        coef[1]  = 18'h10000;
        entry[1] = 24'hFFFFFC;
        base = done_cnt;
        pulse(3);
        n = t0;
        while (cyc < n + 15) begin
            @(posedge clk);
            #1;
        end
        pulse(3);
        chk("b2b_second_gap", 64'(t0 - n), 64'd16);
        wait_done(base + 2, "b2b");
        chk("b2b_result", 64'(res_at_done), 64'h0FFFFFE);
        chk("b2b_latency", 64'(done_at - t0), 64'(NTAPS + 4));
        repeat (4) @(negedge clk);
        chk("b2b_two_done", 64'(done_cnt - base), 64'd2);
        chk("b2b_no_overrun", 64'(overrun_o), 64'd0);

        // Random taps and coefficients
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++) begin
                entry[k] = 24'($urandom);
                coef[k]  = 18'($urandom);
            end
            if (r % 4 == 0) for (int k = 0; k < 16; k++) coef[k] = 18'($urandom_range(0, 8191));
            run_check($sformatf("rand%0d", r), int'($urandom_range(2, 6)), 1'b0, 24'h0);
        end
        chk("rand_no_overrun", 64'(overrun_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
